unpack_ctrl: RTL and testbench
==============================

# unpack_ctrl

Sequencing controller for the decompressor's unpacker datapath. Owns one cache line's decode from start to done: fetches 128-bit compressed chunks over a valid/ready handshake, decides each cycle whether the unpacker decodes a code pair (`o_decompressor_en`) and/or reloads its window (`o_update`), and keeps its own count of buffered bits. It also counts decoded words and handles uncompressed lines as a single-chunk bypass. It sits between the line-fetch interface and the unpacker/length-generator pair.

## Interface
- `WIDTH`, 128: fetch chunk width in bits.
- `WIDTH196`, 196: unpacker window capacity in bits.
- `LINE_WORDS`, 8: 16-bit words per line; must be even.
- `MAX_PAIR`, 36: worst-case bits consumed by one code pair.
- `REFILL_TH`, 68: refill only when the post-consume bit count is ≤ this value. Must satisfy `REFILL_TH + WIDTH ≤ WIDTH196`.
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_start` in 1: start a line. Accepted only in IDLE.
- `i_comp_flag` in 1: sampled with `i_start`. 1 = compressed line, 0 = raw line.
- `i_num_chunks` in 2: compressed chunks in the line (1–3), sampled with `i_start`. Value 0 is treated as 1.
- `o_fetch_ready` in/out: out 1. Ready to accept a chunk.
- `i_fetch_valid` in 1: chunk valid.
- `i_fetch_data` in WIDTH: chunk payload.
- `i_total_length` in 7: unpacker's first_length + second_length for the current window.
- `o_decompressor_en` out 1: unpacker decode enable.
- `o_update` out 1: unpacker window load strobe.
- `o_comp_flag` out 1: registered `i_comp_flag` of the active line.
- `o_chunk` out WIDTH: chunk data forwarded to the window merge. Equals `i_fetch_data` when `o_update` = 1.
- `o_remain` out 8: registered buffered-bit count.
- `o_word_cnt` out 4: decoded words in the current line.
- `o_bypass_valid` out 1: raw chunk valid on `o_chunk`.
- `o_busy` out 1: not IDLE.
- `o_done` out 1: one-cycle pulse when the line completes.

## Operation
- **States:** IDLE, PRIME, DECODE, BYPASS, DONE.
- **IDLE:**
  - All strobes are 0.
  - On `i_start`: latch the flag and chunk count, clear counters.
  - Next state is PRIME if compressed, else BYPASS.
- **PRIME:**
  - `o_fetch_ready` = 1.
  - On handshake: `o_update` = 1, `o_decompressor_en` = 0, remain ← 128, chunks_taken ← 1, next state DECODE.
- **DECODE:**
  - `o_decompressor_en` = (remain ≥ MAX_PAIR) OR (chunks_taken == num_chunks).
  - consumed = en ? `i_total_length` : 0.
  - after = remain − consumed.
  - `o_fetch_ready` = (chunks_taken < num_chunks) AND (after ≤ REFILL_TH).
  - `o_update` = `o_fetch_ready` AND `i_fetch_valid`.
  - remain ← after + (`o_update` ? 128 : 0).
  - chunks_taken increments on `o_update`.
  - word_cnt increments by 2 on each en cycle.
  - If en AND word_cnt + 2 == LINE_WORDS, next state is DONE.
- **BYPASS:**
  - `o_fetch_ready` = 1.
  - On handshake: `o_bypass_valid` = 1, `o_chunk` = data, next state DONE.
- **DONE:**
  - `o_done` = 1 for one cycle, then IDLE.
  - Chunks not yet consumed are not requested.
- **Width rules:**
  - All bit arithmetic is 8-bit unsigned.
  - If consumed > remain (corrupt stream), clamp after to 0, and latch sticky `err` (internal, visible via debug only). Decoding continues until word_cnt completes.
- **Simultaneous events:**
  - `i_start` outside IDLE is ignored.
  - Decode and refill in the same cycle are both applied in the one remain update.
  - `i_reset` has priority over everything, mid-line included: state → IDLE, counters → 0.

## Timing
- Reset values:
  - All outputs 0.
  - `o_remain` = 0, `o_word_cnt` = 0, state IDLE.
- Latency:
  - `i_start` → PRIME after 1 cycle.
  - First decode occurs the cycle after the PRIME handshake.
  - With no stalls, a line of LINE_WORDS = 8 takes 1 + 1 + 4 + 1 cycles from start to `o_done`.
- Handshake rules:
  - A transfer occurs only when `o_fetch_ready` and `i_fetch_valid` are both 1.
  - Data is consumed in that same cycle.
  - `o_fetch_ready` may depend combinationally on `i_total_length`.
  - Upstream must not make valid depend on ready.
- A stall (en = 0 with no handshake) leaves remain and word_cnt unchanged.

## Structure
- Package `unpack_pkg`:
  - state enum `unpack_state_e`;
  - localparams CHUNK_BITS = 128, WIN_BITS = 196;
  - shared width constants used by the unpacker.
- One sub-module, `unpack_budget`: the combinational en/after/ready/update/next-remain calculation, so it can be unit-tested.

## Test plan
1. Reset mid-DECODE with remain = 90 and word_cnt = 4 → next cycle IDLE, `o_remain` = 0, `o_word_cnt` = 0, no `o_done`.
2. Compressed line, num_chunks = 1, `i_total_length` = 12 every cycle, fetch valid immediately → `o_update` in PRIME only, four en cycles, remain sequence 128 → 116 → 104 → 92 → 80, `o_done` 7 cycles after start.
3. num_chunks = 2, `i_total_length` = 30 → remain 128 → 98 → 68. Second chunk taken in the cycle where after = 38, remain → 166. No second refill request.
4. Refill starvation: remain = 20 < MAX_PAIR, chunks remaining, `i_fetch_valid` = 0 for 3 cycles → en = 0, remain/word_cnt frozen. Valid rises → update, remain = 148, en resumes the next cycle.
5. Raw line, `i_comp_flag` = 0, data 0x...A5 → `o_bypass_valid` with `o_chunk` = data on the handshake cycle, `o_done` the next cycle, en never asserted.
6. Overflow protection: `i_total_length` = 40 with remain = 30 and all chunks taken → after clamps to 0, err set, decoding finishes at word_cnt = 8.

Source files
------------

// File: rtl/unpack_pkg.sv
// Shared types and width constants for the unpacker sequencing controller.
package unpack_pkg;

    localparam int CHUNK_BITS  = 128;
    localparam int WIN_BITS    = 196;
    localparam int REMAIN_W    = 8;
    localparam int LEN_W       = 7;
    localparam int WCNT_W      = 4;
    localparam int CHUNK_CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_DECODE = 3'd2,
        ST_BYPASS = 3'd3,
        ST_DONE   = 3'd4
    } unpack_state_e;

    // A chunk count of zero is treated as a single-chunk line.
    function automatic logic [CHUNK_CNT_W-1:0] norm_chunks(input logic [CHUNK_CNT_W-1:0] n);
        return (n == 2'd0) ? 2'd1 : n;
    endfunction

endpackage

// File: rtl/unpack_budget.sv
// Combinational bit-budget step for one DECODE cycle: decode enable,
// refill request/accept and the next buffered-bit count.
module unpack_budget
    import unpack_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int MAX_PAIR  = 36,
    parameter int REFILL_TH = 68
) (
    input  logic                   i_active,
    input  logic [REMAIN_W-1:0]    i_remain,
    input  logic [LEN_W-1:0]       i_total_length,
    input  logic [CHUNK_CNT_W-1:0] i_chunks_taken,
    input  logic [CHUNK_CNT_W-1:0] i_num_chunks,
    input  logic                   i_fetch_valid,
    output logic                   o_en,
    output logic                   o_ready,
    output logic                   o_update,
    output logic                   o_overflow,
    output logic [REMAIN_W-1:0]    o_remain_next
);

    localparam logic [REMAIN_W-1:0] MAX_PAIR_B  = REMAIN_W'(MAX_PAIR);
    localparam logic [REMAIN_W-1:0] REFILL_TH_B = REMAIN_W'(REFILL_TH);
    localparam logic [REMAIN_W-1:0] CHUNK_B     = REMAIN_W'(WIDTH);

    logic [REMAIN_W-1:0] consumed_s;
    logic [REMAIN_W-1:0] after_s;
    logic                all_taken_s;

    // Once every chunk is buffered the tail is decoded regardless of the pair budget.
    always_comb begin
        all_taken_s = (i_chunks_taken == i_num_chunks);
        o_en        = i_active && ((i_remain >= MAX_PAIR_B) || all_taken_s);
        consumed_s  = o_en ? {1'b0, i_total_length} : 8'd0;
        if (consumed_s > i_remain) begin
            after_s    = 8'd0;
            o_overflow = 1'b1;
        end else begin
            after_s    = i_remain - consumed_s;
            o_overflow = 1'b0;
        end
        o_ready       = i_active && (i_chunks_taken < i_num_chunks) && (after_s <= REFILL_TH_B);
        o_update      = o_ready && i_fetch_valid;
        o_remain_next = after_s + (o_update ? CHUNK_B : 8'd0);
    end

endmodule

// File: rtl/unpack_ctrl.sv
// Line-level sequencer: primes the unpacker window, paces decode against
// buffered bits and refills, and passes raw lines straight through.
module unpack_ctrl
    import unpack_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int WIDTH196   = 196,
    parameter int LINE_WORDS = 8,
    parameter int MAX_PAIR   = 36,
    parameter int REFILL_TH  = 68
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_comp_flag,
    input  logic [1:0]          i_num_chunks,
    output logic                o_fetch_ready,
    input  logic                i_fetch_valid,
    input  logic [WIDTH-1:0]    i_fetch_data,
    input  logic [6:0]          i_total_length,
    output logic                o_decompressor_en,
    output logic                o_update,
    output logic                o_comp_flag,
    output logic [WIDTH-1:0]    o_chunk,
    output logic [7:0]          o_remain,
    output logic [3:0]          o_word_cnt,
    output logic                o_bypass_valid,
    output logic                o_busy,
    output logic                o_done
);

    if ((REFILL_TH + WIDTH) > WIDTH196) begin : g_bad_refill_th
        $error("unpack_ctrl: REFILL_TH + WIDTH exceeds window capacity");
    end
    if ((LINE_WORDS % 2) != 0) begin : g_bad_line_words
        $error("unpack_ctrl: LINE_WORDS must be even");
    end

    localparam logic [WCNT_W-1:0]   LINE_WORDS_B = WCNT_W'(LINE_WORDS);
    localparam logic [REMAIN_W-1:0] CHUNK_B      = REMAIN_W'(WIDTH);

    unpack_state_e          state_q, state_d;
    logic                   comp_flag_q, comp_flag_d;
    logic [CHUNK_CNT_W-1:0] num_chunks_q, num_chunks_d;
    logic [CHUNK_CNT_W-1:0] chunks_taken_q, chunks_taken_d;
    logic [REMAIN_W-1:0]    remain_q, remain_d;
    logic [WCNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic                   err_q, err_d;
    logic                   busy_q, done_q;

    logic                   b_en_s, b_ready_s, b_update_s, b_overflow_s;
    logic [REMAIN_W-1:0]    b_remain_next_s;

    unpack_budget #(
        .WIDTH     (WIDTH),
        .MAX_PAIR  (MAX_PAIR),
        .REFILL_TH (REFILL_TH)
    ) u_budget (
        .i_active       (state_q == ST_DECODE),
        .i_remain       (remain_q),
        .i_total_length (i_total_length),
        .i_chunks_taken (chunks_taken_q),
        .i_num_chunks   (num_chunks_q),
        .i_fetch_valid  (i_fetch_valid),
        .o_en           (b_en_s),
        .o_ready        (b_ready_s),
        .o_update       (b_update_s),
        .o_overflow     (b_overflow_s),
        .o_remain_next  (b_remain_next_s)
    );

    // Next-state and handshake strobes; strobes depend on live inputs.
    always_comb begin
        state_d           = state_q;
        comp_flag_d       = comp_flag_q;
        num_chunks_d      = num_chunks_q;
        chunks_taken_d    = chunks_taken_q;
        remain_d          = remain_q;
        word_cnt_d        = word_cnt_q;
        err_d             = err_q;
        o_fetch_ready     = 1'b0;
        o_update          = 1'b0;
        o_decompressor_en = 1'b0;
        o_bypass_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    comp_flag_d    = i_comp_flag;
                    num_chunks_d   = norm_chunks(i_num_chunks);
                    chunks_taken_d = 2'd0;
                    remain_d       = 8'd0;
                    word_cnt_d     = 4'd0;
                    state_d        = i_comp_flag ? ST_PRIME : ST_BYPASS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                o_fetch_ready = 1'b1;
                if (i_fetch_valid) begin
                    o_update       = 1'b1;
                    remain_d       = CHUNK_B;
                    chunks_taken_d = 2'd1;
                    state_d        = ST_DECODE;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_DECODE: begin
                o_fetch_ready     = b_ready_s;
                o_update          = b_update_s;
                o_decompressor_en = b_en_s;
                remain_d          = b_remain_next_s;
                if (b_update_s) begin
                    chunks_taken_d = chunks_taken_q + 2'd1;
                end else begin
                    chunks_taken_d = chunks_taken_q;
                end
                // A corrupt stream is flagged but the line still runs to its word count.
                if (b_en_s) begin
                    word_cnt_d = word_cnt_q + 4'd2;
                    err_d      = err_q | b_overflow_s;
                    if ((word_cnt_q + 4'd2) == LINE_WORDS_B) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DECODE;
                    end
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            ST_BYPASS: begin
                o_fetch_ready = 1'b1;
                if (i_fetch_valid) begin
                    o_bypass_valid = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    state_d = ST_BYPASS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        o_chunk = (o_update || o_bypass_valid) ? i_fetch_data : {WIDTH{1'b0}};
    end

    // State, counters and registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            comp_flag_q    <= 1'b0;
            num_chunks_q   <= 2'd0;
            chunks_taken_q <= 2'd0;
            remain_q       <= 8'd0;
            word_cnt_q     <= 4'd0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            comp_flag_q    <= comp_flag_d;
            num_chunks_q   <= num_chunks_d;
            chunks_taken_q <= chunks_taken_d;
            remain_q       <= remain_d;
            word_cnt_q     <= word_cnt_d;
            err_q          <= err_d;
            busy_q         <= (state_d != ST_IDLE);
            done_q         <= (state_d == ST_DONE);
        end
    end

    assign o_comp_flag = comp_flag_q;
    assign o_remain    = remain_q;
    assign o_word_cnt  = word_cnt_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_unpack_ctrl.sv
// Directed bench for unpack_ctrl: per-cycle vector table plus hand-written
// reset, raw-bypass and error-flag sequences.
`timescale 1ns/1ps
module tb_unpack_ctrl;

    logic         clk = 1'b0;
    logic         i_reset, i_start, i_comp_flag, i_fetch_valid;
    logic [1:0]   i_num_chunks;
    logic [127:0] i_fetch_data;
    logic [6:0]   i_total_length;
    logic         o_fetch_ready, o_decompressor_en, o_update, o_comp_flag;
    logic [127:0] o_chunk;
    logic [7:0]   o_remain;
    logic [3:0]   o_word_cnt;
    logic         o_bypass_valid, o_busy, o_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unpack_ctrl dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_start           (i_start),
        .i_comp_flag       (i_comp_flag),
        .i_num_chunks      (i_num_chunks),
        .o_fetch_ready     (o_fetch_ready),
        .i_fetch_valid     (i_fetch_valid),
        .i_fetch_data      (i_fetch_data),
        .i_total_length    (i_total_length),
        .o_decompressor_en (o_decompressor_en),
        .o_update          (o_update),
        .o_comp_flag       (o_comp_flag),
        .o_chunk           (o_chunk),
        .o_remain          (o_remain),
        .o_word_cnt        (o_word_cnt),
        .o_bypass_valid    (o_bypass_valid),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    typedef struct {
        bit         first;
        logic [1:0] n;
        logic [6:0] tl;
        logic       v;
        logic       exp_ready;
        logic       exp_en;
        logic       exp_upd;
        logic [7:0] exp_rem;
        logic [3:0] exp_wc;
        logic       exp_done;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(bit first, logic [1:0] n, logic [6:0] tl, logic v,
                                logic rdy, logic en, logic upd,
                                logic [7:0] rem, logic [3:0] wc, logic done);
        vec_t r;
        r.first = first; r.n = n; r.tl = tl; r.v = v;
        r.exp_ready = rdy; r.exp_en = en; r.exp_upd = upd;
        r.exp_rem = rem; r.exp_wc = wc; r.exp_done = done;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the DUT one cycle into the new line, at a negedge.
    task automatic start_line(input logic flag, input logic [1:0] n);
        for (int k = 0; k < 10 && o_busy; k++) @(negedge clk);
        chk("idle_before_start", o_busy, 1'b0);
        i_start = 1'b1; i_comp_flag = flag; i_num_chunks = n;
        @(posedge clk); #1;
        chk("busy_after_start", o_busy, 1'b1);
        @(negedge clk);
        i_start = 1'b0; i_comp_flag = 1'b0; i_num_chunks = 2'd0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        logic [127:0] data;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].first) start_line(1'b1, vecs[i].n);
            data = {96'h0, 32'hC0DE_0000 + 32'(i)};
            i_total_length = vecs[i].tl;
            i_fetch_valid  = vecs[i].v;
            i_fetch_data   = data;
            #1;
            chk($sformatf("r%0d_ready", i), o_fetch_ready, vecs[i].exp_ready);
            chk($sformatf("r%0d_en", i), o_decompressor_en, vecs[i].exp_en);
            chk($sformatf("r%0d_update", i), o_update, vecs[i].exp_upd);
            chk($sformatf("r%0d_chunk", i), o_chunk, vecs[i].exp_upd ? data : 128'h0);
            @(posedge clk); #1;
            chk($sformatf("r%0d_remain", i), o_remain, vecs[i].exp_rem);
            chk($sformatf("r%0d_word_cnt", i), o_word_cnt, vecs[i].exp_wc);
            chk($sformatf("r%0d_done", i), o_done, vecs[i].exp_done);
            chk($sformatf("r%0d_comp_flag", i), o_comp_flag, 1'b1);
            @(negedge clk);
        end
        i_fetch_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] raw;
        // first,n,tl,v | ready,en,upd | remain,word_cnt,done after the edge
        vecs[0]  = mk(1, 1, 19, 1, 1, 0, 1, 128, 0, 0);
        vecs[1]  = mk(0, 1, 19, 0, 0, 1, 0, 109, 2, 0);
        vecs[2]  = mk(0, 1, 19, 0, 0, 1, 0,  90, 4, 0);
        vecs[3]  = mk(1, 1, 12, 1, 1, 0, 1, 128, 0, 0);
        vecs[4]  = mk(0, 1, 12, 1, 0, 1, 0, 116, 2, 0);
        vecs[5]  = mk(0, 1, 12, 1, 0, 1, 0, 104, 4, 0);
        vecs[6]  = mk(0, 1, 12, 1, 0, 1, 0,  92, 6, 0);
        vecs[7]  = mk(0, 1, 12, 1, 0, 1, 0,  80, 8, 1);
        vecs[8]  = mk(1, 2, 30, 1, 1, 0, 1, 128, 0, 0);
        vecs[9]  = mk(0, 2, 30, 0, 0, 1, 0,  98, 2, 0);
        vecs[10] = mk(0, 2, 30, 0, 1, 1, 0,  68, 4, 0);
        vecs[11] = mk(0, 2, 30, 1, 1, 1, 1, 166, 6, 0);
        vecs[12] = mk(0, 2, 30, 1, 0, 1, 0, 136, 8, 1);
        vecs[13] = mk(1, 2, 54, 1, 1, 0, 1, 128, 0, 0);
        vecs[14] = mk(0, 2, 54, 0, 0, 1, 0,  74, 2, 0);
        vecs[15] = mk(0, 2, 54, 0, 1, 1, 0,  20, 4, 0);
        vecs[16] = mk(0, 2, 54, 0, 1, 0, 0,  20, 4, 0);
        vecs[17] = mk(0, 2, 54, 0, 1, 0, 0,  20, 4, 0);
        vecs[18] = mk(0, 2, 54, 0, 1, 0, 0,  20, 4, 0);
        vecs[19] = mk(0, 2, 54, 1, 1, 0, 1, 148, 4, 0);
        vecs[20] = mk(0, 2, 54, 0, 0, 1, 0,  94, 6, 0);
        vecs[21] = mk(0, 2, 54, 0, 0, 1, 0,  40, 8, 1);
        vecs[22] = mk(1, 1, 49, 1, 1, 0, 1, 128, 0, 0);
        vecs[23] = mk(0, 1, 49, 0, 0, 1, 0,  79, 2, 0);
        vecs[24] = mk(0, 1, 49, 0, 0, 1, 0,  30, 4, 0);
        vecs[25] = mk(0, 1, 40, 0, 0, 1, 0,   0, 6, 0);
        vecs[26] = mk(0, 1, 40, 0, 0, 1, 0,   0, 8, 1);

        i_reset = 1'b1; i_start = 1'b0; i_comp_flag = 1'b0; i_num_chunks = 2'd0;
        i_fetch_valid = 1'b0; i_fetch_data = 128'h0; i_total_length = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_remain", o_remain, 8'd0);
        chk("rst_word_cnt", o_word_cnt, 4'd0);
        chk("rst_ready", o_fetch_ready, 1'b0);
        chk("rst_update", o_update, 1'b0);
        chk("rst_en", o_decompressor_en, 1'b0);
        chk("rst_bypass", o_bypass_valid, 1'b0);
        chk("rst_chunk", o_chunk, 128'h0);
        chk("rst_comp_flag", o_comp_flag, 1'b0);
        @(negedge clk);

        // Reset in the middle of a line at remain 90, word_cnt 4
        run_rows(0, 2);
        i_reset = 1'b1; i_total_length = 7'd19;
        @(posedge clk); #1;
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_remain", o_remain, 8'd0);
        chk("midrst_word_cnt", o_word_cnt, 4'd0);
        chk("midrst_done", o_done, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);

        run_rows(3, 21);
        chk("err_clear", dut.err_q, 1'b0);

        // Raw line bypass
        start_line(1'b0, 2'd0);
        chk("raw_comp_flag", o_comp_flag, 1'b0);
        chk("raw_ready_wait", o_fetch_ready, 1'b1);
        chk("raw_bypass_wait", o_bypass_valid, 1'b0);
        raw = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
        i_fetch_data = raw; i_fetch_valid = 1'b1;
        #1;
        chk("raw_bypass", o_bypass_valid, 1'b1);
        chk("raw_chunk", o_chunk, raw);
        chk("raw_en", o_decompressor_en, 1'b0);
        chk("raw_update", o_update, 1'b0);
        @(posedge clk); #1;
        chk("raw_done", o_done, 1'b1);
        chk("raw_bypass_drop", o_bypass_valid, 1'b0);
        @(negedge clk);
        i_fetch_valid = 1'b0;
        @(posedge clk); #1;
        chk("raw_done_pulse", o_done, 1'b0);
        chk("raw_idle", o_busy, 1'b0);
        @(negedge clk);

        // Over-consumption clamps to zero and sets the sticky error
        run_rows(22, 26);
        chk("err_set", dut.err_q, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
